// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared single-port memory arbiter between instruction fetch and MEM stage
//
// Purpose: grants one of two requesters (IF, MEM) access to a single-port RAM.
// MEM has priority unless IF has been starved for STARVE_MAX consecutive MEM grants.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   if_req/if_addr/if_flush        fetch request, byte address, discard outstanding fetch
//   if_done/if_rdata/if_stall      fetch complete pulse, instruction word, hold request to PC/IF2ID
//   mem_req/mem_we/mem_addr/wdata  data request, store flag, address, store data
//   mem_done/mem_rdata/misalign    data complete pulse, load data, misaligned-address pulse
//   mem_stall                      hold request to EX2MEM/MEM2WB
//   ram_en/we/addr/wdata           shared RAM command, held for the whole BUSY state
//   ram_rdata/ram_ready            RAM read data and completion handshake
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic          mem_done,
    output logic [31:0]   mem_rdata,
    output logic          mem_misalign,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    input  logic          ram_ready,
    output logic          if_stall,
    output logic          mem_stall
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_starve_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic            r_if_done;
    logic            r_mem_done;
    logic            r_misalign;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_mem_rdata;
    logic            r_flushed;

    logic            w_starved;
    logic            w_misaligned;
    logic            w_grant_mem;
    logic            w_grant_if;
    logic            w_if_complete;
    logic            w_mem_complete;

    always_comb begin
        w_next_state   = r_state;
        w_grant_mem    = 1'b0;
        w_grant_if     = 1'b0;
        w_if_complete  = 1'b0;
        w_mem_complete = 1'b0;
        w_starved      = (r_starve_cnt >= SMAX);
        w_misaligned   = (mem_addr[1:0] != 2'b00);
        case (r_state)
            IDLE: begin
                // A saturated counter only yields to IF when IF is actually
                // asking; otherwise MEM is served rather than idling a cycle.
                if (mem_req && (!w_starved || !if_req)) begin
                    w_grant_mem = 1'b1;
                    // Misaligned accesses are answered from IDLE, never touch RAM.
                    if (!w_misaligned) begin
                        w_next_state = MEM_BUSY;
                    end
                end else if (if_req) begin
                    w_grant_if   = 1'b1;
                    w_next_state = IF_BUSY;
                end
            end
            IF_BUSY: begin
                if (ram_ready) begin
                    w_if_complete = 1'b1;
                    w_next_state  = IDLE;
                end
            end
            MEM_BUSY: begin
                if (ram_ready) begin
                    w_mem_complete = 1'b1;
                    w_next_state   = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_if_done    <= 1'b0;
            r_mem_done   <= 1'b0;
            r_misalign   <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_flushed    <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_misalign <= 1'b0;

            if (!if_req || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_mem && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end

            if (w_grant_mem) begin
                if (w_misaligned) begin
                    r_mem_done  <= 1'b1;
                    r_misalign  <= 1'b1;
                    r_mem_rdata <= '0;
                end else begin
                    r_addr  <= mem_addr;
                    r_we    <= mem_we;
                    r_wdata <= mem_wdata;
                end
            end

            if (w_grant_if) begin
                r_addr    <= if_addr;
                r_we      <= 1'b0;
                r_flushed <= if_flush;
            end else if (r_state == IF_BUSY && if_flush) begin
                r_flushed <= 1'b1;
            end

            // A flushed fetch still finishes on the RAM but is invisible to IF.
            if (w_if_complete && !r_flushed && !if_flush) begin
                r_if_done  <= 1'b1;
                r_if_rdata <= ram_rdata;
            end

            if (w_mem_complete) begin
                r_mem_done  <= 1'b1;
                r_mem_rdata <= ram_rdata;
            end
        end
    end

    assign ram_en       = (r_state != IDLE);
    assign ram_we       = (r_state == MEM_BUSY) && r_we;
    assign ram_addr     = r_addr;
    assign ram_wdata    = r_wdata;
    assign if_done      = r_if_done;
    assign if_rdata     = r_if_rdata;
    assign mem_done     = r_mem_done;
    assign mem_rdata    = r_mem_rdata;
    assign mem_misalign = r_misalign;
    assign if_stall     = if_req & ~r_if_done;
    assign mem_stall    = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        mem_misalign;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        if_stall;
    logic        mem_stall;

    mem_port_arbiter #(.STARVE_MAX(4), .AW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_misalign(mem_misalign),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    // RAM model: word i holds 0x1000_0000 | byte address, except 0x10 holds an LW opcode.
    logic [31:0] ram [0:63];
    assign ram_rdata = ram[ram_addr[7:2]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= (i == 4) ? 32'h8C01_0004 : (32'h1000_0000 | (i << 2));
        end else if (ram_en && ram_we && ram_ready) begin
            ram[ram_addr[7:2]] <= ram_wdata;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic [31:0] rdata;
        logic        misalign;
        logic        chk_data;
    } sb_t;
    sb_t sb[$];

    task automatic push(input logic is_mem, input logic [31:0] rdata, input logic mis, input logic cd);
        sb_t e;
        e.is_mem = is_mem; e.rdata = rdata; e.misalign = mis; e.chk_data = cd;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (!reset && (if_done || mem_done)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_kind", {31'd0, mem_done}, {31'd0, e.is_mem});
                if (e.chk_data) chk("sb_rdata", mem_done ? mem_rdata : if_rdata, e.rdata);
                chk("sb_misalign", {31'd0, mem_misalign}, {31'd0, e.misalign});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic want_mem, output int cyc);
        logic seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            tick();
            cyc++;
            seen = want_mem ? mem_done : if_done;
        end
        if (!seen) chk("timeout_done", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc, nm, ni, we0;
        reset = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; ram_ready = 1'b1;
        repeat (3) tick();
        chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        reset = 1'b0;
        tick();

        // single fetch, zero wait states
        if_addr = 32'h10; if_req = 1'b1;
        push(1'b0, 32'h8C01_0004, 1'b0, 1'b1);
        we0 = we_cnt;
        wait_done(1'b0, cyc);
        chk("fetch_latency", cyc, 32'd2);
        if_req = 1'b0;
        tick();
        chk("fetch_ram_we", we_cnt - we0, 32'd0);
        chk("fetch_done_pulse", {31'd0, if_done}, 32'd0);
        chk("fetch_rdata_hold", if_rdata, 32'h8C01_0004);

        // simultaneous requests: MEM store first, then IF
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 32'h14;
        push(1'b1, 32'd0, 1'b0, 1'b0);
        push(1'b0, 32'h1000_0014, 1'b0, 1'b1);
        tick();
        chk("store_ram_en", {31'd0, ram_en}, 32'd1);
        chk("store_ram_we", {31'd0, ram_we}, 32'd1);
        chk("store_ram_addr", ram_addr, 32'h20);
        chk("store_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        wait_done(1'b1, cyc);
        chk("store_latency", cyc, 32'd1);
        mem_req = 1'b0; mem_we = 1'b0;
        wait_done(1'b0, cyc);
        chk("if_after_mem", cyc, 32'd2);
        if_req = 1'b0;
        mem_req = 1'b1; mem_addr = 32'h20;
        push(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_done(1'b1, cyc);
        chk("load_latency", cyc, 32'd2);
        mem_req = 1'b0;
        tick();

        // starvation: 6 back-to-back loads with IF waiting
        for (int k = 0; k < 4; k++) push(1'b1, 32'h1000_0040 + 4 * k, 1'b0, 1'b1);
        push(1'b0, 32'h1000_0008, 1'b0, 1'b1);
        push(1'b1, 32'h1000_0050, 1'b0, 1'b1);
        push(1'b1, 32'h1000_0054, 1'b0, 1'b1);
        push(1'b0, 32'h1000_0008, 1'b0, 1'b1);
        if_addr = 32'h08; if_req = 1'b1;
        mem_addr = 32'h40; mem_req = 1'b1;
        nm = 0; ni = 0; cyc = 0;
        while ((nm < 6 || ni < 2) && cyc < 200) begin
            tick();
            cyc++;
            if (mem_done) begin
                nm++;
                if (nm == 6) mem_req = 1'b0;
                else mem_addr = 32'h40 + 4 * nm;
            end
            if (if_done) begin
                ni++;
                if (ni == 2) if_req = 1'b0;
            end
        end
        chk("starve_mem_count", nm, 32'd6);
        chk("starve_if_count", ni, 32'd2);
        tick();

        // flushed fetch with wait states
        ram_ready = 1'b0;
        if_addr = 32'h0C; if_req = 1'b1;
        tick();
        chk("flush_ram_en_1", {31'd0, ram_en}, 32'd1);
        chk("flush_if_stall", {31'd0, if_stall}, 32'd1);
        tick();
        if_flush = 1'b1;
        chk("flush_ram_en_2", {31'd0, ram_en}, 32'd1);
        tick();
        if_flush = 1'b0;
        chk("flush_ram_en_3", {31'd0, ram_en}, 32'd1);
        tick();
        ram_ready = 1'b1;
        chk("flush_ram_en_4", {31'd0, ram_en}, 32'd1);
        tick();
        chk("flush_no_done", {31'd0, if_done}, 32'd0);
        chk("flush_ram_en_off", {31'd0, ram_en}, 32'd0);
        chk("flush_rdata_hold", if_rdata, 32'h1000_0008);
        if_req = 1'b0;
        tick();
        chk("flush_no_done_late", {31'd0, if_done}, 32'd0);

        // misaligned load
        mem_addr = 32'h22; mem_we = 1'b0; mem_req = 1'b1;
        push(1'b1, 32'd0, 1'b1, 1'b1);
        tick();
        chk("mis_done", {31'd0, mem_done}, 32'd1);
        chk("mis_flag", {31'd0, mem_misalign}, 32'd1);
        chk("mis_rdata", mem_rdata, 32'd0);
        chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
        mem_req = 1'b0;
        tick();
        chk("mis_pulse", {31'd0, mem_done | mem_misalign}, 32'd0);

        // reset in the 2nd MEM_BUSY cycle
        ram_ready = 1'b0;
        mem_addr = 32'h30; mem_req = 1'b1;
        tick();
        chk("rst_busy_ram_en", {31'd0, ram_en}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_ram_en", {31'd0, ram_en}, 32'd0);
        chk("midrst_mem_done", {31'd0, mem_done}, 32'd0);
        chk("midrst_if_rdata", if_rdata, 32'd0);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        chk("midrst_ram_addr", ram_addr, 32'd0);
        chk("midrst_ram_wdata", ram_wdata, 32'd0);
        reset = 1'b0; mem_req = 1'b0; ram_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_done", {31'd0, mem_done}, 32'd0);
        if_addr = 32'h10; if_req = 1'b1;
        push(1'b0, 32'h8C01_0004, 1'b0, 1'b1);
        wait_done(1'b0, cyc);
        chk("post_rst_fetch", cyc, 32'd2);
        if_req = 1'b0;
        repeat (2) tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
